// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter
// Purpose  : Two-requester round-robin arbiter owning the select line of a
//            WIDTH-bit bank of multiplexer_1bit cells (shared bus A/B).
// Revision : 1.0 - initial release
// ============================================================================

module multiplexer_1bit (
    input  logic a,
    input  logic b,
    input  logic select_bit,
    output logic y
);
    assign y = select_bit ? a : b;
endmodule

module mux_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             grant_a,
    output logic             grant_b,
    output logic             select_bit,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(MAX_BURST);
    localparam logic [CNT_W:0]   BURST_LIM = (CNT_W+1)'(MAX_BURST);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;
    logic             burst_done;
    logic             last_a;

    // Extra bit keeps cnt+1 from wrapping when cnt sits at saturation.
    assign cnt_inc    = {1'b0, cnt} + (CNT_W+1)'(1);
    assign burst_done = (cnt_inc >= BURST_LIM);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_a && req_b)
                    state_nxt = last_a ? OWN_B : OWN_A;
                else if (req_a)
                    state_nxt = OWN_A;
                else if (req_b)
                    state_nxt = OWN_B;
                else
                    state_nxt = IDLE;
            end
            OWN_A: begin
                if (!req_a)
                    state_nxt = req_b ? OWN_B : IDLE;
                else if (req_b && burst_done)
                    state_nxt = OWN_B;
                else
                    state_nxt = OWN_A;
            end
            OWN_B: begin
                if (!req_b)
                    state_nxt = req_a ? OWN_A : IDLE;
                else if (req_a && burst_done)
                    state_nxt = OWN_A;
                else
                    state_nxt = OWN_B;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant_a    <= 1'b0;
            grant_b    <= 1'b0;
            select_bit <= 1'b0;
            cnt        <= '0;
            last_a     <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant_a    <= (state_nxt == OWN_A);
            grant_b    <= (state_nxt == OWN_B);
            select_bit <= (state_nxt == OWN_A);
            if (state_nxt != state) begin
                cnt <= '0;
                if (state_nxt != IDLE)
                    last_a <= (state_nxt == OWN_A);
            end else if (state_nxt != IDLE && cnt != CNT_SAT) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign valid_out = grant_a | grant_b;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mux
            multiplexer_1bit u_mux (
                .a          (data_a[gi]),
                .b          (data_b[gi]),
                .select_bit (select_bit),
                .y          (data_out[gi])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Two-requester round-robin arbiter that owns the select line of a WIDTH-bit bank of `multiplexer_1bit` instances, sharing one output bus between source A and source B. It grants ownership on request, holds it while the owner keeps requesting, and pre-empts the owner after MAX_BURST cycles when the other side is waiting. It sits between the two data producers and the shared bus consumer, and replaces hand-driven `Select_bit` wiring wherever two sources contend for one path.

## Interface
- WIDTH, 8: data bus width; the number of `multiplexer_1bit` instances.
- MAX_BURST, 4: maximum consecutive owned cycles while the other side requests; legal range 1..7.
- CNT_W, 3: burst counter width; must satisfy MAX_BURST < 2^CNT_W.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_a  input  1  source A requests the bus.
- req_b  input  1  source B requests the bus.
- data_a  input  WIDTH  source A data.
- data_b  input  WIDTH  source B data.
- grant_a  output  1  registered; A owns the bus.
- grant_b  output  1  registered; B owns the bus.
- select_bit  output  1  registered; 1 selects A, 0 selects B. Drives every mux instance.
- data_out  output  WIDTH  combinational mux output: data_a when select_bit=1, else data_b.
- valid_out  output  1  grant_a | grant_b.

## Operation
- States: IDLE, OWN_A, OWN_B. Encoding is free. grant_a=1 only in OWN_A, grant_b=1 only in OWN_B, and select_bit=1 only in OWN_A.
- last_owner flag: records the most recently granted side. It breaks ties only.
- Burst counter cnt: cleared on entry to OWN_A or OWN_B, increments each cycle the state is held, and saturates at MAX_BURST.
- IDLE:
  - req_a only: go to OWN_A.
  - req_b only: go to OWN_B.
  - Both: grant the side that is not last_owner.
  - Neither: stay in IDLE.
- OWN_A (OWN_B is symmetric):
  - req_a=0 and req_b=1: go to OWN_B.
  - req_a=0 and req_b=0: go to IDLE.
  - req_a=1, req_b=1 and cnt+1 ≥ MAX_BURST (the owner has held MAX_BURST cycles): go to OWN_B (pre-emption).
  - req_a=1 otherwise: stay; the owner holds indefinitely while uncontended.
- An owner-to-other handover takes one edge. The old grant falls and the new grant rises on the same edge, with no IDLE bubble.
- grant_a and grant_b are never both 1.
- data_out is built only from the `multiplexer_1bit` bank, with no additional registering. In IDLE, data_out = data_b and valid_out=0; consumers ignore data_out in that case.
- Reset values, applied immediately on reset assertion:
  - state=IDLE, grant_a=0, grant_b=0, select_bit=0, valid_out=0, cnt=0.
  - last_owner=B, so A wins the first tie.
- Reset mid-ownership drops the grant asynchronously. No handover completes.

## Timing
- Request-to-grant latency is 1 cycle: a request sampled at edge n produces the grant after edge n, when the bus is free.
- Release latency is 1 cycle: req dropped before edge n causes the grant to fall after edge n.
- Pre-emption: with both requests held continuously, the owner holds exactly MAX_BURST cycles, then the other side gets exactly MAX_BURST cycles. This alternation is steady-state.
- select_bit changes on the same edge as the grants. data_out follows after combinational mux delay only.
- Requesters hold req until granted; dropping req before grant is legal and simply cancels the request.

## Test plan
- Reset: assert reset mid-OWN_B with req_b=1 → grant_b, select_bit and valid_out go to 0 immediately (before the next edge). After release with req_a=req_b=1, the first grant is grant_a=1, one cycle later.
- Single requester: req_a=1 for 10 cycles, data_a=8'hA5 → grant_a=1 from cycle 1 through 10, data_out=8'hA5 and select_bit=1 throughout, no pre-emption. Drop req_a → IDLE after one edge.
- Contention (MAX_BURST=4): req_a=req_b=1 continuously from reset → grants alternate A×4, B×4, A×4. Grants are never overlapping and never both 0 after the first grant.
- Direct handover: in OWN_A, drop req_a while req_b=1 → grant_b=1 on the very next cycle and select_bit=0, with no IDLE cycle between. data_out switches from data_a=8'h3C to data_b=8'hC3.
- Tie break: A owns then releases to IDLE; one idle cycle later both request → grant_b (last_owner=A).
- Parameter sweep: MAX_BURST=1 with both requesting → strict per-cycle alternation. MAX_BURST=7 (CNT_W=3) → 7-cycle bursts, counter never wraps.
